// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the serial-in, parallel-out receiver.
package sipo_rx_pkg;

    typedef enum logic {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } sipo_state_e;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_rx_sva.sv
// Property checker for sipo_rx: head stability under backpressure, occupancy bound,
// and pushes only from word assembly.
module sipo_rx_sva
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   out_valid,
    input logic                   out_ready,
    input logic [WIDTH-1:0]       out_data,
    input logic [$clog2(DEPTH):0] level,
    input logic                   push,
    input sipo_state_e            state
);

    localparam logic [$clog2(DEPTH):0] DEPTH_L = ($clog2(DEPTH)+1)'(DEPTH);

    a_stable_head: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_data));

    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        level <= DEPTH_L);

    a_no_push_in_hunt: assert property (@(posedge clk) disable iff (rst)
        push |-> (state == ASSEMBLE));

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and wrap-bit pointers; the head word is read
// straight from storage so it is visible in the cycle after the push edge.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign level     = wptr_q - rptr_q;
    assign empty     = (level == {(AW+1){1'b0}});
    assign full      = (level == DEPTH_L);
    assign head_data = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (do_pop_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        if (do_push_s) begin
            mem_d[wptr_q[AW-1:0]] = push_data;
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: aligns on frame_start, assembles MSB-first words and
// queues them in an output FIFO with a sticky overflow flag for dropped words.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   frame_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   overflow,
    input  logic                   overflow_clr,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sipo_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] word_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             drop_s;

    assign word_s    = {shift_q, bit_in};
    assign out_valid = !empty_s;
    assign pop_s     = out_valid && out_ready;
    assign drop_s    = push_s && full_s && !pop_s;
    assign overflow  = overflow_q;

    // A frame_start bit always restarts assembly, even one bit short of completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                state_d    = ASSEMBLE;
                cnt_d      = CW'(1);
                shift_d    = '0;
                shift_d[0] = bit_in;
            end else if (state_q == ASSEMBLE) begin
                if (cnt_q == CNT_LAST) begin
                    push_s  = 1'b1;
                    state_d = HUNT;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    shift_d = word_s[WIDTH-2:0];
                    cnt_d   = cnt_q + CW'(1);
                end
            end else begin
                state_d = HUNT;
            end
        end else begin
            state_d = state_q;
        end
    end

    // A drop that coincides with a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Assembly and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .head_data (out_data),
        .empty     (empty_s),
        .full      (full_s),
        .level     (level)
    );

    sipo_rx_sva #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_sva (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .push      (push_s),
        .state     (state_q)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4, DEPTH=2) with a queue-based reference model
// checked every cycle plus literal expectations per scenario.
module tb_sipo_rx;

    localparam int W = 4;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_valid = 1'b0;
    logic         bit_in = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         overflow;
    logic         overflow_clr = 1'b0;
    logic [1:0]   level;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_rx #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .frame_start  (frame_start),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: bits since the last frame_start, FIFO as a queue.
    int m_q[$];
    int m_nbits = 0;
    int m_acc = 0;
    bit m_ovf = 1'b0;
    bit m_live = 1'b0;
    bit m_done;
    bit m_pop;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_nbits = 0;
            m_acc = 0;
            m_ovf = 1'b0;
            m_live = 1'b1;
        end else begin
            m_pop = (m_q.size() > 0) && out_ready;
            m_done = 1'b0;
            if (bit_valid) begin
                if (frame_start) begin
                    m_nbits = 1;
                    m_acc = int'(bit_in);
                end else if (m_nbits > 0) begin
                    m_acc = m_acc * 2 + int'(bit_in);
                    m_nbits++;
                    if (m_nbits == W) begin
                        m_done = 1'b1;
                        m_nbits = 0;
                    end
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (overflow_clr) m_ovf = 1'b0;
            if (m_done) begin
                if (m_q.size() < D) m_q.push_back(m_acc);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_valid", int'(out_valid), int'(m_q.size() > 0));
            check("model_level", int'(level), m_q.size());
            check("model_overflow", int'(overflow), int'(m_ovf));
            if (m_q.size() > 0) check("model_data", int'(out_data), m_q[0]);
        end
    end

    // All tasks start and end at a negative clock edge.
    task automatic send_bit(input logic b, input logic fs);
        bit_valid = 1'b1;
        bit_in = b;
        frame_start = fs;
        @(negedge clk);
        bit_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], i == W - 1);
            if (i > 0) idle(gap);
        end
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_level", int'(level), 0);
        check("reset_overflow", int'(overflow), 0);

        // 1: plain word, consumer ready
        out_ready = 1'b1;
        send_word(4'hB, 0);
        check("s1_valid", int'(out_valid), 1);
        check("s1_data", int'(out_data), 32'hB);
        check("s1_model", m_q[0], 32'hB);
        idle(1);
        check("s1_drained", int'(out_valid), 0);
        check("s1_level", int'(level), 0);

        // 2: gaps between bits
        send_bit(1'b0, 1'b1); idle(3);
        send_bit(1'b1, 1'b0); idle(3);
        send_bit(1'b1, 1'b0); idle(3);
        check("s2_no_early", int'(out_valid), 0);
        send_bit(1'b0, 1'b0);
        check("s2_data", int'(out_data), 32'h6);
        idle(1);

        // 3: early frame_start discards partial word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("s3_no_early", int'(out_valid), 0);
        send_bit(1'b0, 1'b0);
        check("s3_valid", int'(out_valid), 1);
        check("s3_data", int'(out_data), 32'h2);
        check("s3_overflow", int'(overflow), 0);
        idle(1);

        // 4: overflow under backpressure
        out_ready = 1'b0;
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        send_word(4'hF, 0);
        idle(2);
        check("s4_level", int'(level), 2);
        check("s4_overflow", int'(overflow), 1);
        check("s4_model_ovf", int'(m_ovf), 1);
        check("s4_head", int'(out_data), 32'hA);
        out_ready = 1'b1;
        idle(1);
        check("s4_second", int'(out_data), 32'h5);
        check("s4_level1", int'(level), 1);
        idle(1);
        check("s4_empty", int'(out_valid), 0);
        out_ready = 1'b0;
        overflow_clr = 1'b1;
        idle(1);
        overflow_clr = 1'b0;
        check("s4_cleared", int'(overflow), 0);

        // 5: completion on a full FIFO coinciding with a pop
        send_word(4'h3, 0);
        send_word(4'h7, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("s5_full", int'(level), 2);
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check("s5_level", int'(level), 2);
        check("s5_overflow", int'(overflow), 0);
        check("s5_head", int'(out_data), 32'h7);
        idle(1);
        check("s5_last", int'(out_data), 32'hC);
        idle(1);
        check("s5_empty", int'(out_valid), 0);

        // 6: reset mid-frame with a queued word
        out_ready = 1'b0;
        send_word(4'hE, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("s6_queued", int'(level), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("s6_valid", int'(out_valid), 0);
        check("s6_level", int'(level), 0);
        out_ready = 1'b1;
        send_word(4'h9, 1);
        check("s6_data", int'(out_data), 32'h9);
        idle(3);
        check("s6_done", int'(out_valid), 0);

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
